// File: rtl/spi_acc_pkg.sv
// Shared encodings for the SPI accelerator readback path: FSM states and half-word selects.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package spi_acc_pkg;

    typedef enum logic [3:0] {
        RB_IDLE      = 4'd0,
        RB_ENABLE    = 4'd1,
        RB_READ_REQ  = 4'd2,
        RB_READ_WAIT = 4'd3,
        RB_SEND_HI   = 4'd4,
        RB_SEND_LO   = 4'd5,
        RB_NEXT      = 4'd6,
        RB_END_DONE  = 4'd7,
        RB_SEND_CSUM = 4'd8
    } rb_state_e;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/spi_acc_tx_hs.sv
// Half-word holding register with a valid/ready handshake toward the SPI transmitter.
// Latency: a load presents its data as valid on the following cycle.
// Backpressure: valid and data hold until tx_rdy; a load on the firing cycle keeps valid up.
module spi_acc_tx_hs
#(
    parameter int DAT_W = 8
)
(
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic             load,
    input  logic [DAT_W-1:0] load_dat,
    input  logic             tx_rdy,
    output logic             tx_vld,
    output logic [DAT_W-1:0] tx_dat,
    output logic             tx_fire
);

    assign tx_fire = tx_vld & tx_rdy;

    // The FSM only loads when the register is empty or firing, so data never changes under a stall.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            tx_vld <= 1'b0;
            tx_dat <= '0;
        end else if (load) begin
            tx_vld <= 1'b1;
            tx_dat <= load_dat;
        end else if (tx_fire) begin
            tx_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_acc_readback.sv
// Readback FSM: streams SNN words to the SPI transmitter as high then low half-words (SPI_ACC_READBACK_CSUM_EN appends an XOR checksum).
// Latency: spi_en 1 cycle after start, first half-word 4 cycles after start, then 4+RD_LAT cycles per word.
// Backpressure: tx valid holds with stable data until i_spi_tx_ready; the FSM stalls in the send states meanwhile.
module spi_acc_readback
    import spi_acc_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
)
(
    input  logic                wb_clk,
    input  logic                wb_rst_n,
    input  logic                i_if_start,
    input  logic [ADDR_W-1:0]   i_if_base,
    input  logic [ADDR_W-1:0]   i_if_len,
    output logic                o_if_busy,
    output logic                o_if_done,
    output logic                o_snn_re,
    output logic [ADDR_W-1:0]   o_snn_addr,
    input  logic [WORD_W-1:0]   i_snn_rdata,
    output logic                o_spi_en,
    output logic [WORD_W/2-1:0] o_spi_tx_data,
    output logic                o_spi_tx_valid,
    input  logic                i_spi_tx_ready
);

    localparam int HALF_W = WORD_W / 2;
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    function automatic logic [HALF_W-1:0] half_sel(input logic [WORD_W-1:0] w, input logic sel);
        return sel ? w[WORD_W-1:HALF_W] : w[HALF_W-1:0];
    endfunction

    rb_state_e         state_q;
    rb_state_e         state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rem_q;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [LAT_W-1:0]  lat_q;
    logic [HALF_W-1:0] cap_lo_q;
    logic              lat_last;
    logic              last_word;
    logic              tx_load;
    logic [HALF_W-1:0] tx_load_dat;
    logic              tx_fire;
`ifdef SPI_ACC_READBACK_CSUM_EN
    logic [HALF_W-1:0] csum_q;
`endif

    assign lat_last  = (lat_q == LAT_W'(RD_LAT - 1));
    assign last_word = (rem_q == ADDR_W'(1));

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) state_q <= RB_IDLE;
        else           state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            RB_IDLE:      if (i_if_start) state_nxt = (i_if_len == '0) ? RB_END_DONE : RB_ENABLE;
            RB_ENABLE:    state_nxt = RB_READ_REQ;
            RB_READ_REQ:  state_nxt = RB_READ_WAIT;
            RB_READ_WAIT: if (lat_last) state_nxt = RB_SEND_HI;
            RB_SEND_HI:   if (tx_fire) state_nxt = RB_SEND_LO;
            RB_SEND_LO:   if (tx_fire) state_nxt = RB_NEXT;
`ifdef SPI_ACC_READBACK_CSUM_EN
            RB_NEXT:      state_nxt = last_word ? RB_SEND_CSUM : RB_READ_REQ;
            RB_SEND_CSUM: if (tx_fire) state_nxt = RB_END_DONE;
`else
            RB_NEXT:      state_nxt = last_word ? RB_END_DONE : RB_READ_REQ;
`endif
            RB_END_DONE:  state_nxt = RB_IDLE;
            default:      state_nxt = RB_IDLE;
        endcase
    end

    // The high half goes straight from the read bus into the holding register, so only the low half is captured.
    always_comb begin
        o_if_busy   = (state_q != RB_IDLE);
        o_if_done   = 1'b0;
        o_snn_re    = 1'b0;
        o_snn_addr  = addr_hold_q;
        o_spi_en    = 1'b0;
        tx_load     = 1'b0;
        tx_load_dat = '0;
        case (state_q)
            RB_ENABLE:    o_spi_en = 1'b1;
            RB_READ_REQ: begin
                o_snn_re   = 1'b1;
                o_snn_addr = addr_q;
            end
            RB_READ_WAIT: if (lat_last) begin
                tx_load     = 1'b1;
                tx_load_dat = half_sel(i_snn_rdata, HALF_HI);
            end
            RB_SEND_HI:   if (tx_fire) begin
                tx_load     = 1'b1;
                tx_load_dat = cap_lo_q;
            end
`ifdef SPI_ACC_READBACK_CSUM_EN
            RB_NEXT:      if (last_word) begin
                tx_load     = 1'b1;
                tx_load_dat = csum_q;
            end
`endif
            RB_END_DONE:  o_if_done = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            addr_q      <= '0;
            rem_q       <= '0;
            addr_hold_q <= '0;
            lat_q       <= '0;
            cap_lo_q    <= '0;
        end else begin
            case (state_q)
                RB_IDLE: if (i_if_start && (i_if_len != '0)) begin
                    addr_q <= i_if_base;
                    rem_q  <= i_if_len;
                end
                RB_READ_REQ: begin
                    addr_hold_q <= addr_q;
                    lat_q       <= '0;
                end
                RB_READ_WAIT: begin
                    lat_q <= lat_q + 1'b1;
                    if (lat_last) cap_lo_q <= half_sel(i_snn_rdata, HALF_LO);
                end
                RB_NEXT: if (!last_word) begin
                    addr_q <= addr_q + 1'b1;
                    rem_q  <= rem_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_ACC_READBACK_CSUM_EN
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            csum_q <= '0;
        end else if (state_q == RB_ENABLE) begin
            csum_q <= '0;
        end else if (tx_fire && ((state_q == RB_SEND_HI) || (state_q == RB_SEND_LO))) begin
            csum_q <= csum_q ^ o_spi_tx_data;
        end
    end
`endif

    spi_acc_tx_hs #(.DAT_W(HALF_W)) u_tx_hs (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .load     (tx_load),
        .load_dat (tx_load_dat),
        .tx_rdy   (i_spi_tx_ready),
        .tx_vld   (o_spi_tx_valid),
        .tx_dat   (o_spi_tx_data),
        .tx_fire  (tx_fire)
    );

endmodule
